camera_yuv_stream_gen: RTL

//  Transmit side of the camera pixel bus: emulates an 8-bit YUV422 camera source (pclk/href/vsync/cam_data).

---
 rtl/camera_yuv_stream_gen_if.sv | 20 ++
 rtl/camera_yuv_stream_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/camera_yuv_stream_gen_if.sv
// Pixel-pair handshake between an RGB888 producer and the YUV422 camera emulator.
//   in_valid : producer has a pixel pair on r1/g1/b1 (first) and r2/g2/b2 (second)
//   in_ready : consumer takes the pair on this edge when in_valid is also high
// master = producer side, slave = camera_yuv_stream_gen side.
interface camera_yuv_stream_gen_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r1, g1, b1;
  logic [7:0] r2, g2, b2;

  modport master (
    output in_valid, r1, g1, b1, r2, g2, b2,
    input  in_ready
  );

  modport slave (
    input  in_valid, r1, g1, b1, r2, g2, b2,
    output in_ready
  );
endinterface

// File: rtl/camera_yuv_stream_gen.sv
// 8-bit YUV422 camera source emulator. Takes RGB888 pixel pairs over a valid/ready handshake,
// converts each pair to a Y1,U,Y2,V byte group (BT.601 integer) and frames the stream with
// vsync/href timing.
// Ports:
//   pclk, reset      byte clock; synchronous active-high reset
//   enable           start frames (sampled in idle and at the last cycle of a frame)
//   pix              pixel-pair handshake (slave side)
//   href, vsync      line / vertical sync timing
//   cam_data         Y1,U,Y2,V byte stream, 0 while href is low
//   frame_start      one-cycle pulse in the first vsync cycle of a frame
//   line_count       current active line, 0 outside the active region
//   underflow        pulses in a ready cycle where no pair was offered
module camera_yuv_stream_gen #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned H_BLANK       = 144,
  parameter int unsigned V_SYNC_LINES  = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic                    pclk,
  input  logic                    reset,
  input  logic                    enable,
  camera_yuv_stream_gen_if.slave  pix,
  output logic                    href,
  output logic                    vsync,
  output logic [7:0]              cam_data,
  output logic                    frame_start,
  output logic [9:0]              line_count,
  output logic                    underflow
);
  localparam int unsigned LineLen = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW      = $clog2(LineLen);
  localparam logic [HW-1:0] HLast      = HW'(LineLen - 1);
  localparam logic [HW-1:0] HPreLine   = HW'(LineLen - 2);
  localparam logic [HW-1:0] HActEnd    = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] HLastReady = HW'(2 * H_ACTIVE - 2);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  // Position counters describe the cycle currently shown on the registered outputs.
  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic [9:0]    vlast;

  always_comb begin
    vlast = '0;
    case (state_q)
      StVsync:  vlast = 10'(V_SYNC_LINES - 1);
      StVback:  vlast = 10'(V_BACK_LINES - 1);
      StActive: vlast = 10'(V_ACTIVE - 1);
      StVfront: vlast = 10'(V_FRONT_LINES - 1);
      default:  vlast = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (state_q == StIdle) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (enable) state_d = StVsync;
    end else if (hcnt_q != HLast) begin
      hcnt_d = hcnt_q + 1'b1;
    end else begin
      hcnt_d = '0;
      if (vcnt_q != vlast) begin
        vcnt_d = vcnt_q + 1'b1;
      end else begin
        vcnt_d = '0;
        case (state_q)
          StVsync:  state_d = StVback;
          StVback:  state_d = StActive;
          StActive: state_d = StVfront;
          StVfront: state_d = enable ? StVsync : StIdle;
          default:  state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Ready two cycles ahead of every Y1 slot: mid-line slots, plus the second-to-last cycle of
  // the line period preceding an active line (back porch or the previous active line's blank).
  assign pix.in_ready =
      ((state_q == StActive) && (hcnt_q < HLastReady) && (hcnt_q[1:0] == 2'd2)) ||
      ((hcnt_q == HPreLine) && (((state_q == StActive) && (vcnt_q != vlast)) ||
                                ((state_q == StVback) && (vcnt_q == vlast))));
  assign underflow = pix.in_ready & ~pix.in_valid;

  // A missing pair is converted as all-zero RGB, which yields black (16,128,16,128).
  logic [7:0] r1s, g1s, b1s, r2s, g2s, b2s;
  logic [8:0] rsum, gsum, bsum;
  assign r1s  = pix.in_valid ? pix.r1 : 8'd0;
  assign g1s  = pix.in_valid ? pix.g1 : 8'd0;
  assign b1s  = pix.in_valid ? pix.b1 : 8'd0;
  assign r2s  = pix.in_valid ? pix.r2 : 8'd0;
  assign g2s  = pix.in_valid ? pix.g2 : 8'd0;
  assign b2s  = pix.in_valid ? pix.b2 : 8'd0;
  assign rsum = {1'b0, r1s} + {1'b0, r2s} + 9'd1;
  assign gsum = {1'b0, g1s} + {1'b0, g2s} + 9'd1;
  assign bsum = {1'b0, b1s} + {1'b0, b2s} + 9'd1;

  function automatic logic signed [17:0] mul(input logic [7:0] x, input int c);
    return 18'($signed({24'd0, x}) * c);
  endfunction

  function automatic logic [7:0] to_byte(input logic signed [17:0] a, b, c,
                                         input logic [7:0] offs);
    logic signed [17:0] s;
    s = ((a + b + c + 18'sd128) >>> 8) + $signed({10'd0, offs});
    if (s < 18'sd0) return 8'd0;
    if (s > 18'sd255) return 8'd255;
    return s[7:0];
  endfunction

  // Stage 1: products, captured on the handshake edge.
  logic signed [17:0] py1_q [3];
  logic signed [17:0] py2_q [3];
  logic signed [17:0] pu_q  [3];
  logic signed [17:0] pv_q  [3];

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        py1_q[i] <= '0;
        py2_q[i] <= '0;
        pu_q[i]  <= '0;
        pv_q[i]  <= '0;
      end
    end else if (pix.in_ready) begin
      py1_q[0] <= mul(r1s, 66);
      py1_q[1] <= mul(g1s, 129);
      py1_q[2] <= mul(b1s, 25);
      py2_q[0] <= mul(r2s, 66);
      py2_q[1] <= mul(g2s, 129);
      py2_q[2] <= mul(b2s, 25);
      pu_q[0]  <= mul(rsum[8:1], -38);
      pu_q[1]  <= mul(gsum[8:1], -74);
      pu_q[2]  <= mul(bsum[8:1], 112);
      pv_q[0]  <= mul(rsum[8:1], 112);
      pv_q[1]  <= mul(gsum[8:1], -94);
      pv_q[2]  <= mul(bsum[8:1], -18);
    end
  end

  // Stage 2: sums/clamps. Y1 goes straight into cam_data; U, Y2, V wait in hold registers.
  logic [7:0] y1_c, u_c, y2_c, v_c;
  logic [7:0] u_hold_q, y2_hold_q, v_hold_q;
  assign y1_c = to_byte(py1_q[0], py1_q[1], py1_q[2], 8'd16);
  assign y2_c = to_byte(py2_q[0], py2_q[1], py2_q[2], 8'd16);
  assign u_c  = to_byte(pu_q[0], pu_q[1], pu_q[2], 8'd128);
  assign v_c  = to_byte(pv_q[0], pv_q[1], pv_q[2], 8'd128);

  logic       href_d, vsync_d, frame_start_d, load_group;
  logic [7:0] cam_data_d;
  logic [9:0] line_count_d;

  always_comb begin
    href_d        = (state_d == StActive) && (hcnt_d < HActEnd);
    vsync_d       = (state_d == StVsync);
    frame_start_d = (state_d == StVsync) && (hcnt_d == '0) && (vcnt_d == '0);
    line_count_d  = (state_d == StActive) ? vcnt_d : 10'd0;
    load_group    = href_d && (hcnt_d[1:0] == 2'd0);
    cam_data_d    = 8'd0;
    if (href_d) begin
      case (hcnt_d[1:0])
        2'd0:    cam_data_d = y1_c;
        2'd1:    cam_data_d = u_hold_q;
        2'd2:    cam_data_d = y2_hold_q;
        default: cam_data_d = v_hold_q;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      href        <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      line_count  <= '0;
      cam_data    <= '0;
      u_hold_q    <= '0;
      y2_hold_q   <= '0;
      v_hold_q    <= '0;
    end else begin
      href        <= href_d;
      vsync       <= vsync_d;
      frame_start <= frame_start_d;
      line_count  <= line_count_d;
      cam_data    <= cam_data_d;
      if (load_group) begin
        u_hold_q  <= u_c;
        y2_hold_q <= y2_c;
        v_hold_q  <= v_c;
      end
    end
  end
endmodule
